adc_cmd_arbiter: RTL
====================

// Module: adc_cmd_arbiter
// PURPOSE
//  Shares the ADC power/calibration sequencer between two requesters: host command decoder and auto power manager.
//  Round-robin arbitrates, checks command legality against the live ADC state, and issues one-cycle control pulses.
//  Tracks each command to completion or timeout and returns a one-cycle ack or error to the owning requester.
//  Sits between the command decoders and the ADC sequencer's adcPwrOn/adcPwrOff/adcSleep/adcWake/adcRunCal inputs.
// PARAMETERS
//  TIMEOUT_CYCLES  50_000_000  max cycles in WAIT before error
//  TW              26          timeout counter width; must satisfy 2^TW > TIMEOUT_CYCLES
// PORTS
//  Clock       in   1   system clock
//  Reset       in   1   synchronous, active-high
//  HostReq     in   1   host request level; held until HostAck/HostErr
//  HostCmd     in   3   host command; stable while HostReq high
//  HostAck     out  1   one-cycle pulse: host command completed
//  HostErr     out  1   one-cycle pulse: host command illegal/failed/timed out
//  AutoReq     in   1   auto manager request level
//  AutoCmd     in   3   auto manager command
//  AutoAck     out  1   one-cycle pulse: auto command completed
//  AutoErr     out  1   one-cycle pulse: auto command illegal/failed/timed out
//  AdcState    in   4   live sequencer state code (0 OFF, 5 CAL_REQ, 6 CAL, 8 SAMPLING, 10 LOW_PWR_IDLE, 13 SHUTDOWN)
//  CmdPwrOn    out  1   pulse to sequencer
//  CmdPwrOff   out  1   pulse to sequencer
//  CmdSleep    out  1   pulse to sequencer
//  CmdWake     out  1   pulse to sequencer
//  CmdRunCal   out  1   pulse to sequencer
//  Busy        out  1   high in every state except IDLE
// BEHAVIOUR
//  Commands: 1 PWR_ON, 2 PWR_OFF, 3 SLEEP, 4 WAKE, 5 RUN_CAL; 0, 6, 7 are illegal.
//  Legal start state / target state: PWR_ON 0->8; PWR_OFF 8 or 10 ->0; SLEEP 8->10; WAKE 10->8; RUN_CAL 8->8.
//  States: IDLE, CHECK, ISSUE, WAIT, RESPOND.
//  IDLE: if any Req, grant (round-robin; on tie, grant the requester not served last; after reset, host wins the first tie);
//    latch cmd, owner, start state (AdcState) -> CHECK.
//  CHECK: illegal code or AdcState != legal start -> RESPOND with err; else -> ISSUE.
//  ISSUE: exactly one Cmd* output high for this single cycle; clear Left flag and timer -> WAIT.
//  WAIT: Left set when AdcState != latched start. Done when Left && AdcState == target -> RESPOND ok.
//    Left && AdcState == 0 when target != 0 -> RESPOND err (enable dropped). Timer == TIMEOUT_CYCLES-1 -> RESPOND err.
//    Completion has priority over timeout when both occur in the same cycle.
//  RESPOND: owner's Ack or Err high for exactly one cycle; update last-served pointer -> IDLE.
//  Latency: Req seen in cycle n -> Cmd pulse in cycle n+2; illegal cmd -> Err in cycle n+2.
//  Requesters drop Req on the edge ending the Ack/Err cycle; IDLE re-samples on the next cycle, so back-to-back service has no lost grant.
//  Req drop mid-command: ignored; the command still completes and Ack/Err is still pulsed.
//  All outputs registered; never more than one Cmd* high; Ack and Err never both high.
//  Reset, including mid-command: state IDLE, all outputs 0, Left/timer cleared, pointer to host; no Cmd pulse is re-issued.
// TESTING
//  1 AdcState=0, HostReq cmd=1 at cycle 0 -> CmdPwrOn high in cycle 2 only; AdcState 1..8 stepped -> HostAck 1 cycle after 8 seen.
//  2 AdcState=8, HostReq cmd=3 and AutoReq cmd=5 both at cycle 0 -> host served first (CmdSleep); after HostAck, auto checked at AdcState=10 -> AutoErr, no CmdRunCal.
//  3 AdcState=8, AutoReq cmd=5; AdcState 12,5,6,7,8 -> single CmdRunCal, AutoAck only after return to 8 (not on the initial 8).
//  4 TIMEOUT_CYCLES=100, AdcState=10, HostReq cmd=4, AdcState held at 10 -> HostErr exactly 100 cycles after WAIT entry.
//  5 HostReq cmd=6 at any state -> HostErr in cycle 2, no Cmd* pulse; cmd=1 at AdcState=8 -> HostErr.
//  6 Reset asserted during WAIT -> next cycle all outputs 0, Busy 0; a tie after reset grants host.

Source files
------------

// File: rtl/adc_cmd_arbiter.sv
// Round-robin arbiter between host and auto power manager for the ADC sequencer:
// checks command legality, issues one control pulse, tracks completion/timeout, returns ack/err.
module adc_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned TW             = 26
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       HostReq,
  input  logic [2:0] HostCmd,
  output logic       HostAck,
  output logic       HostErr,
  input  logic       AutoReq,
  input  logic [2:0] AutoCmd,
  output logic       AutoAck,
  output logic       AutoErr,
  input  logic [3:0] AdcState,
  output logic       CmdPwrOn,
  output logic       CmdPwrOff,
  output logic       CmdSleep,
  output logic       CmdWake,
  output logic       CmdRunCal,
  output logic       Busy
);

  localparam int unsigned CW = 3;
  localparam int unsigned SW = 4;

  localparam logic [CW-1:0] CMD_PWR_ON  = CW'(1);
  localparam logic [CW-1:0] CMD_PWR_OFF = CW'(2);
  localparam logic [CW-1:0] CMD_SLEEP   = CW'(3);
  localparam logic [CW-1:0] CMD_WAKE    = CW'(4);
  localparam logic [CW-1:0] CMD_RUN_CAL = CW'(5);

  localparam logic [SW-1:0] ADC_OFF      = SW'(0);
  localparam logic [SW-1:0] ADC_SAMPLING = SW'(8);
  localparam logic [SW-1:0] ADC_LOW_PWR  = SW'(10);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RESPOND} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cmd;
  logic          r_owner_auto;
  logic [SW-1:0] r_start;
  logic          r_left;
  logic [TW-1:0] r_timer;
  logic          r_prio_host;

  state_t        w_next;
  logic          w_grant_auto;
  logic          w_ok;
  logic          w_start_ok;
  logic [SW-1:0] w_target;
  logic          w_left_now;
  logic          w_issue;
  logic          w_respond;

  // Legal start state and expected target for the latched command
  always_comb begin
    w_start_ok = 1'b0;
    w_target   = ADC_OFF;
    case (r_cmd)
      CMD_PWR_ON:  begin w_start_ok = (AdcState == ADC_OFF);      w_target = ADC_SAMPLING; end
      CMD_PWR_OFF: begin w_start_ok = (AdcState == ADC_SAMPLING) || (AdcState == ADC_LOW_PWR);
                         w_target   = ADC_OFF; end
      CMD_SLEEP:   begin w_start_ok = (AdcState == ADC_SAMPLING); w_target = ADC_LOW_PWR;  end
      CMD_WAKE:    begin w_start_ok = (AdcState == ADC_LOW_PWR);  w_target = ADC_SAMPLING; end
      CMD_RUN_CAL: begin w_start_ok = (AdcState == ADC_SAMPLING); w_target = ADC_SAMPLING; end
      default:     begin w_start_ok = 1'b0;                       w_target = ADC_OFF;      end
    endcase
  end

  // Next-state logic; outputs are registered from the next state so pulses land in-state
  always_comb begin
    w_next       = r_state;
    w_grant_auto = 1'b0;
    w_ok         = 1'b0;
    w_left_now   = r_left || (AdcState != r_start);
    case (r_state)
      S_IDLE: begin
        if (HostReq || AutoReq) begin
          w_next       = S_CHECK;
          w_grant_auto = AutoReq && (!HostReq || !r_prio_host);
        end
      end
      S_CHECK: begin
        w_next = w_start_ok ? S_ISSUE : S_RESPOND;
      end
      S_ISSUE: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_left_now && (AdcState == w_target)) begin
          w_next = S_RESPOND;
          w_ok   = 1'b1;
        end else if (w_left_now && (AdcState == ADC_OFF) && (w_target != ADC_OFF)) begin
          w_next = S_RESPOND;
        end else if (r_timer == TIMER_LAST) begin
          w_next = S_RESPOND;
        end
      end
      S_RESPOND: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_issue   = (r_state == S_CHECK) && (w_next == S_ISSUE);
  assign w_respond = (r_state != S_RESPOND) && (w_next == S_RESPOND);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_cmd        <= '0;
      r_owner_auto <= 1'b0;
      r_start      <= '0;
      r_left       <= 1'b0;
      r_timer      <= '0;
      r_prio_host  <= 1'b1;
      HostAck      <= 1'b0;
      HostErr      <= 1'b0;
      AutoAck      <= 1'b0;
      AutoErr      <= 1'b0;
      CmdPwrOn     <= 1'b0;
      CmdPwrOff    <= 1'b0;
      CmdSleep     <= 1'b0;
      CmdWake      <= 1'b0;
      CmdRunCal    <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && (w_next == S_CHECK)) begin
        r_cmd        <= w_grant_auto ? AutoCmd : HostCmd;
        r_owner_auto <= w_grant_auto;
        r_start      <= AdcState;
      end
      if (r_state == S_ISSUE) begin
        r_left  <= 1'b0;
        r_timer <= '0;
      end else if (r_state == S_WAIT) begin
        r_left  <= w_left_now;
        r_timer <= r_timer + TW'(1);
      end
      // Pointer favours the requester not served by the command just finished
      if (r_state == S_RESPOND) r_prio_host <= r_owner_auto;
      HostAck   <= w_respond && w_ok  && !r_owner_auto;
      HostErr   <= w_respond && !w_ok && !r_owner_auto;
      AutoAck   <= w_respond && w_ok  && r_owner_auto;
      AutoErr   <= w_respond && !w_ok && r_owner_auto;
      CmdPwrOn  <= w_issue && (r_cmd == CMD_PWR_ON);
      CmdPwrOff <= w_issue && (r_cmd == CMD_PWR_OFF);
      CmdSleep  <= w_issue && (r_cmd == CMD_SLEEP);
      CmdWake   <= w_issue && (r_cmd == CMD_WAKE);
      CmdRunCal <= w_issue && (r_cmd == CMD_RUN_CAL);
      Busy      <= (w_next != S_IDLE);
    end
  end

endmodule
